// File: rtl/issue_queue_if.sv
// Dispatch, writeback-bus, FU-handshake and issue-port bundle of the issue queue.
// The master side drives dispatch, broadcasts and FU readiness; the slave is the queue.
interface issue_queue_if #(
    parameter int PREG_WIDTH = 6,
    parameter int DEPTH      = 16,
    parameter int NUM_FU     = 3,
    parameter int NUM_BUS    = 2,
    parameter int ROB_WIDTH  = 6,
    parameter int PAYLOAD_W  = 48
);
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                          flush;
    logic                          disp_valid;
    logic                          disp_ready;
    logic [FU_W-1:0]               disp_fu;
    logic [PREG_WIDTH-1:0]         disp_rd;
    logic [PREG_WIDTH-1:0]         disp_src1;
    logic [PREG_WIDTH-1:0]         disp_src2;
    logic [31:0]                   disp_data1;
    logic [31:0]                   disp_data2;
    logic                          disp_rdy1;
    logic                          disp_rdy2;
    logic [ROB_WIDTH-1:0]          disp_rob;
    logic [PAYLOAD_W-1:0]          disp_payload;
    logic [NUM_BUS-1:0]            bus_valid;
    logic [NUM_BUS*PREG_WIDTH-1:0] bus_rd;
    logic [NUM_BUS*32-1:0]         bus_data;
    logic [NUM_FU-1:0]             fu_ready;
    logic [NUM_FU-1:0]             issue_valid;
    logic [NUM_FU*PREG_WIDTH-1:0]  issue_rd;
    logic [NUM_FU*32-1:0]          issue_data1;
    logic [NUM_FU*32-1:0]          issue_data2;
    logic [NUM_FU*ROB_WIDTH-1:0]   issue_rob;
    logic [NUM_FU*PAYLOAD_W-1:0]   issue_payload;
    logic [CNT_W-1:0]              count;

    modport master (
        output flush, disp_valid, disp_fu, disp_rd, disp_src1, disp_src2,
               disp_data1, disp_data2, disp_rdy1, disp_rdy2, disp_rob, disp_payload,
               bus_valid, bus_rd, bus_data, fu_ready,
        input  disp_ready, issue_valid, issue_rd, issue_data1, issue_data2,
               issue_rob, issue_payload, count
    );

    modport slave (
        input  flush, disp_valid, disp_fu, disp_rd, disp_src1, disp_src2,
               disp_data1, disp_data2, disp_rdy1, disp_rdy2, disp_rob, disp_payload,
               bus_valid, bus_rd, bus_data, fu_ready,
        output disp_ready, issue_valid, issue_rd, issue_data1, issue_data2,
               issue_rob, issue_payload, count
    );
endinterface

// File: rtl/issue_queue.sv
// Age-ordered reservation station: lowest-free-slot allocation, multi-bus operand
// capture with dispatch bypass, oldest-ready select per FU, flush and sync reset.
module issue_queue #(
    parameter int PREG_WIDTH = 6,
    parameter int DEPTH      = 16,
    parameter int NUM_FU     = 3,
    parameter int NUM_BUS    = 2,
    parameter int ROB_WIDTH  = 6,
    parameter int PAYLOAD_W  = 48
) (
    input logic          clk,
    input logic          rst,
    issue_queue_if.slave iq
);
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [FU_W-1:0]       fu;
        logic [PREG_WIDTH-1:0] rd;
        logic [PREG_WIDTH-1:0] src1;
        logic [PREG_WIDTH-1:0] src2;
        logic [31:0]           data1;
        logic [31:0]           data2;
        logic                  rdy1;
        logic                  rdy2;
        logic [ROB_WIDTH-1:0]  rob;
        logic [PAYLOAD_W-1:0]  payload;
    } entry_t;

    entry_t                     ent_q   [DEPTH];
    logic [DEPTH-1:0]           use_q;
    logic [DEPTH-1:0]           older_q [DEPTH];  // older_q[i][j]: entry j is older than entry i
    logic [CNT_W-1:0]           count_q;
    logic [NUM_FU-1:0]          issue_valid_q;
    logic [NUM_FU*PREG_WIDTH-1:0] issue_rd_q;
    logic [NUM_FU*32-1:0]       issue_data1_q;
    logic [NUM_FU*32-1:0]       issue_data2_q;
    logic [NUM_FU*ROB_WIDTH-1:0] issue_rob_q;
    logic [NUM_FU*PAYLOAD_W-1:0] issue_payload_q;

    logic                       disp_ready;
    logic                       disp_fire;
    logic [IDX_W-1:0]           free_idx;
    entry_t                     new_ent;
    entry_t                     woken   [DEPTH];
    entry_t                     sel_ent [NUM_FU];
    logic [NUM_FU-1:0]          fu_issue;
    logic [DEPTH-1:0]           issued;
    logic [CNT_W-1:0]           n_issued;

    // Returns {rdy, data}; a source that is already ready is never overwritten.
    function automatic logic [32:0] capture(
        input logic                          rdy,
        input logic [PREG_WIDTH-1:0]         src,
        input logic [31:0]                   data,
        input logic [NUM_BUS-1:0]            bv,
        input logic [NUM_BUS*PREG_WIDTH-1:0] brd,
        input logic [NUM_BUS*32-1:0]         bdata
    );
        logic [32:0] r;
        r = {rdy, data};
        for (int b = NUM_BUS - 1; b >= 0; b--) begin
            if (!rdy && bv[b] && brd[b*PREG_WIDTH +: PREG_WIDTH] == src)
                r = {1'b1, bdata[b*32 +: 32]};
        end
        return r;
    endfunction

    assign disp_ready = count_q < CNT_W'(DEPTH);
    assign disp_fire  = iq.disp_valid && disp_ready;

    // NOTE: every variable an always_comb writes gets a default first, so no path can infer a latch.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!use_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        new_ent         = '0;
        new_ent.fu      = iq.disp_fu;
        new_ent.rd      = iq.disp_rd;
        new_ent.src1    = iq.disp_src1;
        new_ent.src2    = iq.disp_src2;
        new_ent.rob     = iq.disp_rob;
        new_ent.payload = iq.disp_payload;
        {new_ent.rdy1, new_ent.data1} = capture(iq.disp_rdy1, iq.disp_src1, iq.disp_data1,
                                                iq.bus_valid, iq.bus_rd, iq.bus_data);
        {new_ent.rdy2, new_ent.data2} = capture(iq.disp_rdy2, iq.disp_src2, iq.disp_data2,
                                                iq.bus_valid, iq.bus_rd, iq.bus_data);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = ent_q[i];
            {woken[i].rdy1, woken[i].data1} = capture(ent_q[i].rdy1, ent_q[i].src1, ent_q[i].data1,
                                                      iq.bus_valid, iq.bus_rd, iq.bus_data);
            {woken[i].rdy2, woken[i].data2} = capture(ent_q[i].rdy2, ent_q[i].src2, ent_q[i].data2,
                                                      iq.bus_valid, iq.bus_rd, iq.bus_data);
        end
    end

    // Oldest-first select: an entry wins when no other requester for its FU is older.
    always_comb begin
        logic [DEPTH-1:0] req;
        logic [DEPTH-1:0] grant;
        issued   = '0;
        n_issued = '0;
        fu_issue = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            req        = '0;
            grant      = '0;
            sel_ent[f] = '0;
            for (int i = 0; i < DEPTH; i++)
                req[i] = use_q[i] && ent_q[i].fu == FU_W'(f) && ent_q[i].rdy1 && ent_q[i].rdy2;
            for (int i = 0; i < DEPTH; i++) begin
                if (iq.fu_ready[f] && req[i] && (req & older_q[i]) == '0) begin
                    grant[i]   = 1'b1;
                    sel_ent[f] = ent_q[i];
                end
            end
            fu_issue[f] = |grant;
            issued      = issued | grant;
            if (fu_issue[f]) n_issued = n_issued + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || iq.flush) begin
            use_q         <= '0;
            count_q       <= '0;
            issue_valid_q <= '0;
        end else begin
            use_q         <= (use_q & ~issued) | (disp_fire ? (DEPTH'(1) << free_idx) : '0);
            count_q       <= count_q + CNT_W'(disp_fire) - n_issued;
            issue_valid_q <= fu_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else if (disp_fire && !iq.flush) begin
            for (int i = 0; i < DEPTH; i++) older_q[i][free_idx] <= 1'b0;
            older_q[free_idx] <= use_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_rd_q      <= '0;
            issue_data1_q   <= '0;
            issue_data2_q   <= '0;
            issue_rob_q     <= '0;
            issue_payload_q <= '0;
        end else if (!iq.flush) begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (fu_issue[f]) begin
                    issue_rd_q[f*PREG_WIDTH +: PREG_WIDTH]     <= sel_ent[f].rd;
                    issue_data1_q[f*32 +: 32]                  <= sel_ent[f].data1;
                    issue_data2_q[f*32 +: 32]                  <= sel_ent[f].data2;
                    issue_rob_q[f*ROB_WIDTH +: ROB_WIDTH]      <= sel_ent[f].rob;
                    issue_payload_q[f*PAYLOAD_W +: PAYLOAD_W]  <= sel_ent[f].payload;
                end
            end
        end
    end

    // NOTE: entry storage has no reset; use_q qualifies every read, so stale contents are harmless.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= (disp_fire && free_idx == IDX_W'(i)) ? new_ent : woken[i];
    end

    assign iq.disp_ready    = disp_ready;
    assign iq.count         = count_q;
    assign iq.issue_valid   = issue_valid_q;
    assign iq.issue_rd      = issue_rd_q;
    assign iq.issue_data1   = issue_data1_q;
    assign iq.issue_data2   = issue_data2_q;
    assign iq.issue_rob     = issue_rob_q;
    assign iq.issue_payload = issue_payload_q;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: reset, issue, wakeup/bypass, age order,
// back-pressure, illegal FU, flush and mid-dispatch reset.
module tb_issue_queue;
    localparam int PREG_WIDTH = 6;
    localparam int DEPTH      = 16;
    localparam int NUM_FU     = 3;
    localparam int NUM_BUS    = 2;
    localparam int ROB_WIDTH  = 6;
    localparam int PAYLOAD_W  = 48;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    issue_queue_if #(
        .PREG_WIDTH(PREG_WIDTH), .DEPTH(DEPTH), .NUM_FU(NUM_FU),
        .NUM_BUS(NUM_BUS), .ROB_WIDTH(ROB_WIDTH), .PAYLOAD_W(PAYLOAD_W)
    ) iq ();

    issue_queue #(
        .PREG_WIDTH(PREG_WIDTH), .DEPTH(DEPTH), .NUM_FU(NUM_FU),
        .NUM_BUS(NUM_BUS), .ROB_WIDTH(ROB_WIDTH), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .iq  (iq.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iq.flush        = 1'b0;
        iq.disp_valid   = 1'b0;
        iq.disp_fu      = '0;
        iq.disp_rd      = '0;
        iq.disp_src1    = '0;
        iq.disp_src2    = '0;
        iq.disp_data1   = '0;
        iq.disp_data2   = '0;
        iq.disp_rdy1    = 1'b0;
        iq.disp_rdy2    = 1'b0;
        iq.disp_rob     = '0;
        iq.disp_payload = '0;
        iq.bus_valid    = '0;
        iq.bus_rd       = '0;
        iq.bus_data     = '0;
    endtask

    task automatic disp(input logic [1:0] fu, input logic [5:0] rd,
                        input logic [5:0] s1, input logic r1, input logic [31:0] d1,
                        input logic [5:0] s2, input logic r2, input logic [31:0] d2,
                        input logic [5:0] rob, input logic [47:0] payload);
        iq.disp_valid   = 1'b1;
        iq.disp_fu      = fu;
        iq.disp_rd      = rd;
        iq.disp_src1    = s1;
        iq.disp_rdy1    = r1;
        iq.disp_data1   = d1;
        iq.disp_src2    = s2;
        iq.disp_rdy2    = r2;
        iq.disp_data2   = d2;
        iq.disp_rob     = rob;
        iq.disp_payload = payload;
    endtask

    task automatic bus(input logic [1:0] v, input logic [5:0] rd1, input logic [31:0] d1,
                       input logic [5:0] rd0, input logic [31:0] d0);
        iq.bus_valid = v;
        iq.bus_rd    = {rd1, rd0};
        iq.bus_data  = {d1, d0};
    endtask

    initial begin
        rst = 1'b1;
        idle();
        iq.fu_ready = 3'b111;
        tick();
        tick();
        check("rst_valid", iq.issue_valid, 0);
        check("rst_count", iq.count, 0);
        check("rst_ready", iq.disp_ready, 1);
        check("rst_data1", iq.issue_data1[63:0], 0);
        check("rst_rd",    iq.issue_rd, 0);
        rst = 1'b0;

        // Basic issue
        disp(2'd0, 6'd5, 6'd1, 1'b1, 32'd3, 6'd2, 1'b1, 32'd4, 6'd1, 48'hABCD_1234_5678);
        tick();
        idle();
        check("basic_count1", iq.count, 1);
        check("basic_novalid", iq.issue_valid, 0);
        tick();
        check("basic_valid", iq.issue_valid, 3'b001);
        check("basic_data1", iq.issue_data1[31:0], 3);
        check("basic_data2", iq.issue_data2[31:0], 4);
        check("basic_rd", iq.issue_rd[5:0], 5);
        check("basic_payload", iq.issue_payload[47:0], 48'hABCD_1234_5678);
        check("basic_count0", iq.count, 0);
        tick();
        check("basic_pulse", iq.issue_valid, 0);

        // Wakeup from bus1; bus0 carries an unrelated tag
        disp(2'd1, 6'd6, 6'd7, 1'b0, 32'd0, 6'd3, 1'b1, 32'h11, 6'd2, 48'h0);
        tick();
        idle();
        bus(2'b11, 6'd7, 32'h55, 6'd8, 32'h99);
        tick();
        idle();
        check("wake_wait", iq.issue_valid, 0);
        tick();
        check("wake_valid", iq.issue_valid, 3'b010);
        check("wake_data1", iq.issue_data1[63:32], 32'h55);
        check("wake_data2", iq.issue_data2[63:32], 32'h11);
        check("wake_rob", iq.issue_rob[11:6], 2);

        // Dispatch bypass: both buses carry tag 9, lowest bus wins; ready src2 keeps its value
        disp(2'd2, 6'd12, 6'd9, 1'b0, 32'd0, 6'd9, 1'b1, 32'h22, 6'd3, 48'h0);
        bus(2'b11, 6'd9, 32'hBB, 6'd9, 32'hAA);
        tick();
        idle();
        tick();
        check("byp_valid", iq.issue_valid, 3'b100);
        check("byp_data1", iq.issue_data1[95:64], 32'hAA);
        check("byp_data2", iq.issue_data2[95:64], 32'h22);

        // Age order independent of slot index: r10->idx1, r11->idx0, r12->idx2
        iq.fu_ready = 3'b100;
        disp(2'd2, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd30, 48'h0);
        tick();
        disp(2'd0, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd10, 48'h0);
        tick();
        check("age_filler_valid", iq.issue_valid, 3'b100);
        check("age_filler_rob", iq.issue_rob[17:12], 30);
        disp(2'd0, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd11, 48'h0);
        tick();
        disp(2'd0, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd12, 48'h0);
        tick();
        disp(2'd1, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd20, 48'h0);
        tick();
        disp(2'd1, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd21, 48'h0);
        tick();
        idle();
        check("age_count5", iq.count, 5);
        check("age_hold", iq.issue_valid, 0);
        iq.fu_ready = 3'b011;
        tick();
        check("age1_valid", iq.issue_valid, 3'b011);
        check("age1_rob0", iq.issue_rob[5:0], 10);
        check("age1_rob1", iq.issue_rob[11:6], 20);
        tick();
        check("age2_valid", iq.issue_valid, 3'b011);
        check("age2_rob0", iq.issue_rob[5:0], 11);
        check("age2_rob1", iq.issue_rob[11:6], 21);
        tick();
        check("age3_valid", iq.issue_valid, 3'b001);
        check("age3_rob0", iq.issue_rob[5:0], 12);
        check("age3_count0", iq.count, 0);

        // Fill the queue with waiting entries
        iq.fu_ready = 3'b111;
        for (int i = 0; i < DEPTH; i++) begin
            disp(2'd0, 6'(i), 6'(32 + i), 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 6'(i), 48'h0);
            tick();
        end
        idle();
        check("full_count", iq.count, DEPTH);
        check("full_ready", iq.disp_ready, 0);
        disp(2'd0, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd63, 48'h0);
        tick();
        idle();
        check("full_ignored_count", iq.count, DEPTH);
        tick();
        check("full_no_issue", iq.issue_valid, 0);
        bus(2'b01, 6'd0, 32'd0, 6'd37, 32'h77);
        tick();
        idle();
        check("full_wake_ready", iq.disp_ready, 0);
        tick();
        check("full_issue_valid", iq.issue_valid, 3'b001);
        check("full_issue_rob", iq.issue_rob[5:0], 5);
        check("full_issue_data1", iq.issue_data1[31:0], 32'h77);
        check("full_count15", iq.count, DEPTH - 1);
        check("full_ready_again", iq.disp_ready, 1);
        disp(2'd1, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd50, 48'h0);
        tick();
        idle();
        check("full_refill_slot", dut.ent_q[5].rob, 50);
        check("full_refill_count", iq.count, DEPTH);
        tick();
        check("full_refill_valid", iq.issue_valid, 3'b010);
        check("full_refill_rob", iq.issue_rob[11:6], 50);

        // Illegal FU index never issues
        iq.flush = 1'b1;
        tick();
        idle();
        check("flush_clear_count", iq.count, 0);
        disp(2'd3, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd7, 48'h0);
        tick();
        idle();
        tick();
        check("badfu_valid", iq.issue_valid, 0);
        check("badfu_count", iq.count, 1);

        // Flush with 5 entries, 2 of them ready
        iq.flush = 1'b1;
        tick();
        idle();
        iq.fu_ready = 3'b000;
        disp(2'd0, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd1, 48'h0);
        tick();
        disp(2'd1, 6'd2, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd2, 48'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            disp(2'd0, 6'd3, 6'd50, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 6'(3 + i), 48'h0);
            tick();
        end
        idle();
        check("flush_pre_count", iq.count, 5);
        iq.fu_ready = 3'b111;
        iq.flush    = 1'b1;
        disp(2'd0, 6'd4, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd9, 48'h0);
        tick();
        idle();
        check("flush_valid", iq.issue_valid, 0);
        check("flush_count", iq.count, 0);
        check("flush_ready", iq.disp_ready, 1);
        tick();
        check("flush_after_valid", iq.issue_valid, 0);
        check("flush_after_count", iq.count, 0);

        // Reset asserted mid-dispatch with issue data fields non-zero
        iq.fu_ready = 3'b000;
        disp(2'd0, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd1, 48'h0);
        tick();
        disp(2'd0, 6'd2, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd2, 48'h0);
        tick();
        check("rst2_pre_count", iq.count, 2);
        iq.fu_ready = 3'b111;
        rst = 1'b1;
        tick();
        idle();
        check("rst2_valid", iq.issue_valid, 0);
        check("rst2_count", iq.count, 0);
        check("rst2_ready", iq.disp_ready, 1);
        check("rst2_data1_zero", iq.issue_data1 == '0, 1);
        check("rst2_data2_zero", iq.issue_data2 == '0, 1);
        check("rst2_rob_zero", iq.issue_rob, 0);
        check("rst2_payload_zero", iq.issue_payload == '0, 1);
        rst = 1'b0;
        tick();
        check("rst2_after_valid", iq.issue_valid, 0);
        check("rst2_after_count", iq.count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
